// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift-and-add multiplier slice:
//   - MULT_W      : default operand width (product is 2*MULT_W bits)
//   - MULT_CNT_W  : bit-counter width for the default operand width
//   - state_t     : controller state encoding (IDLE / BUSY / DONE)
//   - countWidth  : helper giving the counter width for any operand width
// ----------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_W     = 8;
    localparam int MULT_CNT_W = $clog2(MULT_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // One extra bit over $clog2 so the counter can represent WIDTH itself.
    function automatic int countWidth(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// ----------------------------------------------------------------------------
// mult_datapath
// Shift registers, accumulator adder and bit counter for the sequential
// shift-and-add multiplier. Sequenced by the FSM in shift_add_multiplier.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   load_i      capture operands, clear accumulator and counter
//   step_i      process one multiplier bit
//   op1_i       multiplicand (WIDTH bits)
//   op2_i       multiplier   (WIDTH bits)
//   stepAcc_o   accumulator value after the current step (2*WIDTH bits)
//   lastStep_o  current step is the final one
//
// Optional build macro: MULT_EARLY_EXIT_EN -- the last step is also flagged
// as soon as the shifted multiplier becomes zero.
// ----------------------------------------------------------------------------
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     op1_i,
    input  logic [WIDTH-1:0]     op2_i,
    output logic [2*WIDTH-1:0]   stepAcc_o,
    output logic                 lastStep_o
);

    localparam int CW = countWidth(WIDTH);

    logic [2*WIDTH-1:0] mcandQ,  mcandD;
    logic [WIDTH-1:0]   mplierQ, mplierD;
    logic [2*WIDTH-1:0] accQ,    accD;
    logic [CW-1:0]      countQ,  countD;

    logic [2*WIDTH-1:0] accSum;
    logic [WIDTH-1:0]   mplierShift;

    // The multiplicand is pre-extended to 2*WIDTH bits and shifted left
    // each step, so the running sum can never overflow the accumulator.
    always_comb begin
        accSum      = accQ + (mplierQ[0] ? mcandQ : '0);
        mplierShift = mplierQ >> 1;
    end

    // Next-state for the shift registers, accumulator and counter.
    always_comb begin
        mcandD  = mcandQ;
        mplierD = mplierQ;
        accD    = accQ;
        countD  = countQ;
        if (load_i) begin
            mcandD  = {{WIDTH{1'b0}}, op1_i};
            mplierD = op2_i;
            accD    = '0;
            countD  = '0;
        end else if (step_i) begin
            mcandD  = mcandQ << 1;
            mplierD = mplierShift;
            accD    = accSum;
            countD  = countQ + CW'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcandQ  <= '0;
            mplierQ <= '0;
            accQ    <= '0;
            countQ  <= '0;
        end else begin
            mcandQ  <= mcandD;
            mplierQ <= mplierD;
            accQ    <= accD;
            countQ  <= countD;
        end
    end

    // Final-step detection; early exit ends once no set multiplier bits remain.
    always_comb begin
        stepAcc_o = accSum;
`ifdef MULT_EARLY_EXIT_EN
        lastStep_o = (mplierShift == '0) || (countQ == CW'(WIDTH - 1));
`else
        lastStep_o = (countQ == CW'(WIDTH - 1));
`endif
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier
// Sequential WIDTH x WIDTH unsigned shift-and-add multiplier with a 4-phase
// Multiply / MultDone handshake toward the accumulator controller.
//
// Ports:
//   clk                input   system clock, rising edge
//   reset              input   asynchronous active-high reset
//   MultiplicationOp1  input   multiplicand (WIDTH bits)
//   MultiplicationOp2  input   multiplier   (WIDTH bits)
//   Multiply           input   level request, held for the whole operation
//   Product            output  registered 2*WIDTH-bit result
//   MultBusy           output  high while computing
//   MultDone           output  high while result valid and Multiply high
//
// Optional build macro: MULT_EARLY_EXIT_EN -- finish as soon as the remaining
// multiplier bits are all zero (latency 1..WIDTH instead of always WIDTH).
// ----------------------------------------------------------------------------
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     MultiplicationOp1,
    input  logic [WIDTH-1:0]     MultiplicationOp2,
    input  logic                 Multiply,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 MultBusy,
    output logic                 MultDone
);

    state_t             stateQ,   stateD;
    logic [2*WIDTH-1:0] productQ, productD;
    logic               busyQ,    busyD;
    logic               doneQ,    doneD;

    logic               loadDp;
    logic               stepDp;
    logic [2*WIDTH-1:0] stepAcc;
    logic               lastStep;

    mult_datapath #(
        .WIDTH (WIDTH)
    ) uDatapath (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (loadDp),
        .step_i     (stepDp),
        .op1_i      (MultiplicationOp1),
        .op2_i      (MultiplicationOp2),
        .stepAcc_o  (stepAcc),
        .lastStep_o (lastStep)
    );

    // Controller next-state. Dropping Multiply while BUSY aborts and leaves
    // Product untouched; DONE waits for Multiply to drop so a held request
    // never restarts the unit.
    always_comb begin
        stateD   = stateQ;
        productD = productQ;
        busyD    = busyQ;
        doneD    = doneQ;
        loadDp   = 1'b0;
        stepDp   = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                if (Multiply) begin
                    stateD = ST_BUSY;
                    busyD  = 1'b1;
                    loadDp = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!Multiply) begin
                    stateD = ST_IDLE;
                    busyD  = 1'b0;
                end else begin
                    stepDp = 1'b1;
                    if (lastStep) begin
                        stateD   = ST_DONE;
                        productD = stepAcc;
                        busyD    = 1'b0;
                        doneD    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!Multiply) begin
                    stateD = ST_IDLE;
                    doneD  = 1'b0;
                end
            end
            default: begin
                stateD = ST_IDLE;
                busyD  = 1'b0;
                doneD  = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= ST_IDLE;
            productQ <= '0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            productQ <= productD;
            busyQ    <= busyD;
            doneQ    <= doneD;
        end
    end

    assign Product  = productQ;
    assign MultBusy = busyQ;
    assign MultDone = doneQ;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ----------------------------------------------------------------------------
// tb_shift_add_multiplier
// Directed self-checking bench for shift_add_multiplier. Expected products
// are hand-computed constants; expected latency depends on whether the
// bench is built with MULT_EARLY_EXIT_EN.
// ----------------------------------------------------------------------------
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic        multiply;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

`ifdef MULT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    shift_add_multiplier #(
        .WIDTH (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .MultiplicationOp1 (op1),
        .MultiplicationOp2 (op2),
        .Multiply          (multiply),
        .Product           (product),
        .MultBusy          (busy),
        .MultDone          (done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Expected cycles from load edge to MultDone for a given multiplier.
    function automatic int expLatency(input logic [7:0] b);
        if (!EARLY) return 8;
        for (int i = 7; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic req);
        op1      = a;
        op2      = b;
        multiply = req;
    endtask

    // Start a multiply, wait (bounded) for MultDone, check latency/product.
    task automatic runMult(input string tag, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] expProd,
                           input bit scramble);
        int cycles;
        bit busyOk;
        @(negedge clk);
        applyStimulus(a, b, 1'b1);
        @(negedge clk);
        cycles = 0;
        busyOk = 1'b1;
        while (done !== 1'b1 && cycles < 20) begin
            if (busy !== 1'b1) busyOk = 1'b0;
            if (scramble && cycles == 1) applyStimulus(~a, b ^ 8'h5A, 1'b1);
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, " latency"}, 16'(cycles), 16'(expLatency(b)));
        checkOutput({tag, " busyDuring"}, {15'd0, busyOk}, 16'd1);
        checkOutput({tag, " product"}, product, expProd);
        checkOutput({tag, " busyAtDone"}, {15'd0, busy}, 16'd0);
    endtask

    // Release the request and confirm return to IDLE on the next edge.
    task automatic dropRequest(input string tag);
        @(negedge clk);
        multiply = 1'b0;
        @(negedge clk);
        checkOutput({tag, " doneCleared"}, {15'd0, done}, 16'd0);
        checkOutput({tag, " busyCleared"}, {15'd0, busy}, 16'd0);
    endtask

    initial begin
        bit sawDone;

        // Reset state
        reset = 1'b1;
        applyStimulus(8'h00, 8'h00, 1'b0);
        #2;
        checkOutput("reset product", product, 16'h0000);
        checkOutput("reset busy", {15'd0, busy}, 16'd0);
        checkOutput("reset done", {15'd0, done}, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic multiply and handshake
        runMult("3x5", 8'd3, 8'd5, 16'h000F, 1'b0);
        dropRequest("3x5");

        // Full-scale operands, inputs disturbed mid-operation
        runMult("FFxFF", 8'hFF, 8'hFF, 16'hFE01, 1'b1);

        // Held request must not restart
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold done", {15'd0, done}, 16'd1);
            checkOutput("hold product", product, 16'hFE01);
            checkOutput("hold busy", {15'd0, busy}, 16'd0);
        end
        dropRequest("FFxFF");

        runMult("12x34", 8'h12, 8'h34, 16'h03A8, 1'b0);
        dropRequest("12x34");

        // Abort: drop Multiply during BUSY cycle 4
        sawDone = 1'b0;
        @(negedge clk);
        applyStimulus(8'd7, 8'd9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) sawDone = 1'b1;
        end
        checkOutput("abort busyBefore", {15'd0, busy}, 16'd1);
        multiply = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) sawDone = 1'b1;
        end
        checkOutput("abort neverDone", {15'd0, sawDone}, 16'd0);
        checkOutput("abort product", product, 16'h03A8);
        checkOutput("abort busy", {15'd0, busy}, 16'd0);

        // Asynchronous reset in the middle of BUSY
        @(negedge clk);
        applyStimulus(8'd7, 8'd9, 1'b1);
        for (int i = 0; i < 3; i++) @(negedge clk);
        checkOutput("midReset busyBefore", {15'd0, busy}, 16'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("midReset product", product, 16'h0000);
        checkOutput("midReset busy", {15'd0, busy}, 16'd0);
        checkOutput("midReset done", {15'd0, done}, 16'd0);
        @(negedge clk);
        multiply = 1'b0;
        reset    = 1'b0;

        // Zero multiplier
        runMult("ABx00", 8'hAB, 8'h00, 16'h0000, 1'b0);
        dropRequest("ABx00");

        // Short and long multipliers (latency differs only with early exit)
        runMult("10x3", 8'd10, 8'd3, 16'h001E, 1'b0);
        dropRequest("10x3");
        runMult("55x80", 8'h55, 8'h80, 16'h2A80, 1'b0);
        dropRequest("55x80");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
